fb_swap_controller: RTL and testbench

- Double-buffer manager for the two framebuffer banks.
- Serves three clients:
  - Scan-out reads: pixel coordinates from the video controller, always mapped to the front bank.
  - GPU/rasterizer writes: valid/ready handshake, always mapped to the back bank.
  - Buffer swap: requested by the renderer, executed only at the start of vertical blanking so scan-out never tears.
- Sits between the video controller, the rasterizer and the dual-port framebuffer RAM.

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_addr_gen.sv | 41 ++++
 rtl/fb_swap_controller.sv | 183 ++++++++++++++++++
 tb/tb_fb_swap_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, swap FSM state type and banked address type.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 400;
  localparam int unsigned FB_HEIGHT = 300;
  localparam int unsigned X_BITS    = $clog2(FB_WIDTH);
  localparam int unsigned Y_BITS    = $clog2(FB_HEIGHT);
  localparam int unsigned ADDR_BITS = $clog2(FB_WIDTH * FB_HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VBLANK,
    CLEAR
  } fb_swap_state_t;

  // {bank, linear pixel address}
  typedef logic [ADDR_BITS:0] fb_addr_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Registered (x,y) -> {bank, y*FB_WIDTH + x} with a registered in-range hit flag.
// hit is high the cycle after a request whose coordinates were inside the frame.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              bank,
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  output fb_addr_t          addr,
  output logic              hit
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(FB_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(FB_HEIGHT - 1);

  logic                 in_range;
  logic [ADDR_BITS-1:0] lin;

  // Row-major linear address; fits ADDR_BITS for every legal coordinate.
  always_comb begin
    in_range = (x <= X_MAX) && (y <= Y_MAX);
    lin      = ADDR_BITS'(y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(x);
  end

  // Capture address on request; hit marks a request that landed in the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      hit  <= 1'b0;
    end else begin
      hit <= req && in_range;
      if (req) begin
        addr <= {bank, lin};
      end
    end
  end

endmodule

// File: rtl/fb_swap_controller.sv
// Double-buffer manager: scan-out reads from the front bank, GPU writes to the
// back bank, bank swap deferred to the start of vertical blanking.
// Optional macro FB_CLEAR_ON_SWAP_EN: after each swap, fill the new back bank
// with CLEAR_COLOR before acknowledging.
module fb_swap_controller
  import fb_pkg::*;
#(
  parameter int unsigned COLOR_BITS = 16
`ifdef FB_CLEAR_ON_SWAP_EN
  , parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank_start,
  input  logic [X_BITS-1:0]     sc_rd_x,
  input  logic [Y_BITS-1:0]     sc_rd_y,
  output logic [ADDR_BITS:0]    ram_rd_addr,
  input  logic                  gpu_wr_valid,
  output logic                  gpu_wr_ready,
  input  logic [X_BITS-1:0]     gpu_wr_x,
  input  logic [Y_BITS-1:0]     gpu_wr_y,
  input  logic [COLOR_BITS-1:0] gpu_wr_color,
  output logic                  ram_wr_en,
  output logic [ADDR_BITS:0]    ram_wr_addr,
  output logic [COLOR_BITS-1:0] ram_wr_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  front_bank,
  output logic [15:0]           frame_count
);

  fb_swap_state_t state, next_state;

  logic     do_swap;
  logic     ack_set;
  logic     wr_fire;
  logic     rd_hit;
  logic     wr_hit;
  fb_addr_t rd_addr;
  fb_addr_t wr_addr;
  logic [COLOR_BITS-1:0] wr_data_q;

  assign gpu_wr_ready = (state == IDLE) && !reset;
  assign wr_fire      = gpu_wr_valid && gpu_wr_ready;

  fb_addr_gen u_rd_addr (
    .clk   (clk),
    .reset (reset),
    .req   (1'b1),
    .bank  (front_bank),
    .x     (sc_rd_x),
    .y     (sc_rd_y),
    .addr  (rd_addr),
    .hit   (rd_hit)
  );

  fb_addr_gen u_wr_addr (
    .clk   (clk),
    .reset (reset),
    .req   (wr_fire),
    .bank  (~front_bank),
    .x     (gpu_wr_x),
    .y     (gpu_wr_y),
    .addr  (wr_addr),
    .hit   (wr_hit)
  );

  // Out-of-range scan-out reads pixel 0 of the front bank.
  assign ram_rd_addr = rd_hit ? rd_addr : {rd_addr[ADDR_BITS], {ADDR_BITS{1'b0}}};

`ifdef FB_CLEAR_ON_SWAP_EN
  localparam logic [ADDR_BITS-1:0] CLR_LAST = ADDR_BITS'(FB_WIDTH * FB_HEIGHT - 1);

  logic [ADDR_BITS-1:0] clr_cnt;
  logic                 clr_en_q;
  fb_addr_t             clr_addr_q;

  // Clear walker: one write per CLEAR cycle into the new back bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt    <= '0;
      clr_en_q   <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      clr_en_q <= (state == CLEAR);
      if (state == CLEAR) begin
        clr_addr_q <= {~front_bank, clr_cnt};
        clr_cnt    <= clr_cnt + 1'b1;
      end else if (do_swap) begin
        clr_cnt <= '0;
      end
    end
  end

  assign ram_wr_en   = wr_hit || clr_en_q;
  assign ram_wr_addr = clr_en_q ? clr_addr_q : wr_addr;
`else
  assign ram_wr_en   = wr_hit;
  assign ram_wr_addr = wr_addr;
`endif

  assign ram_wr_data = wr_data_q;

  // Write data register, shared by GPU transfers and (optionally) the clear walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_data_q <= '0;
`ifdef FB_CLEAR_ON_SWAP_EN
    end else if (state == CLEAR) begin
      wr_data_q <= CLEAR_COLOR;
`endif
    end else if (wr_fire) begin
      wr_data_q <= gpu_wr_color;
    end
  end

  // Swap FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a request is ignored while swap_ack is high because
  // the renderer has not yet dropped swap_req for the completed swap.
  always_comb begin
    next_state = state;
    do_swap    = 1'b0;
    ack_set    = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req && !swap_ack) begin
          if (vblank_start) begin
            do_swap = 1'b1;
          end else begin
            next_state = WAIT_VBLANK;
          end
        end
      end
      WAIT_VBLANK: begin
        if (vblank_start) begin
          do_swap = 1'b1;
        end
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          next_state = IDLE;
          ack_set    = 1'b1;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
    if (do_swap) begin
`ifdef FB_CLEAR_ON_SWAP_EN
      next_state = CLEAR;
`else
      next_state = IDLE;
      ack_set    = 1'b1;
`endif
    end
  end

  // Bank pointer, frame counter and registered ack pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_bank  <= 1'b0;
      frame_count <= '0;
      swap_ack    <= 1'b0;
    end else begin
      swap_ack <= ack_set;
      if (do_swap) begin
        front_bank  <= ~front_bank;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench for fb_swap_controller (default build, clear feature off).
module tb_fb_swap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank_start;
  logic [8:0]  sc_rd_x, sc_rd_y;
  logic [17:0] ram_rd_addr;
  logic        gpu_wr_valid, gpu_wr_ready;
  logic [8:0]  gpu_wr_x, gpu_wr_y;
  logic [15:0] gpu_wr_color;
  logic        ram_wr_en;
  logic [17:0] ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic        swap_req, swap_ack, front_bank;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_swap_controller #(.COLOR_BITS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .vblank_start (vblank_start),
    .sc_rd_x      (sc_rd_x),
    .sc_rd_y      (sc_rd_y),
    .ram_rd_addr  (ram_rd_addr),
    .gpu_wr_valid (gpu_wr_valid),
    .gpu_wr_ready (gpu_wr_ready),
    .gpu_wr_x     (gpu_wr_x),
    .gpu_wr_y     (gpu_wr_y),
    .gpu_wr_color (gpu_wr_color),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .front_bank   (front_bank),
    .frame_count  (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; vblank_start = 1'b0; swap_req = 1'b0;
    sc_rd_x = 9'd7; sc_rd_y = 9'd3;
    gpu_wr_valid = 1'b0; gpu_wr_x = '0; gpu_wr_y = '0; gpu_wr_color = '0;
    repeat (3) tick();

    check("rst_front_bank", 32'(front_bank), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_swap_ack", 32'(swap_ack), 32'd0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    check("rst_wr_data", 32'(ram_wr_data), 32'd0);
    check("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    check("rst_ready", 32'(gpu_wr_ready), 32'd0);

    reset = 1'b0;
    tick();
    check("idle_ready", 32'(gpu_wr_ready), 32'd1);

    // In-frame write to back bank 1: 2*400+5 = 805
    gpu_wr_valid = 1'b1; gpu_wr_x = 9'd5; gpu_wr_y = 9'd2; gpu_wr_color = 16'hABCD;
    tick();
    gpu_wr_valid = 1'b0;
    check("wr_en", 32'(ram_wr_en), 32'd1);
    check("wr_addr", 32'(ram_wr_addr), 32'(18'h20000 + 18'd805));
    check("wr_data", 32'(ram_wr_data), 32'hABCD);
    tick();
    check("wr_en_idle", 32'(ram_wr_en), 32'd0);

    // Read path corners
    sc_rd_x = 9'd399; sc_rd_y = 9'd299;
    tick();
    check("rd_last", 32'(ram_rd_addr), 32'd119999);
    sc_rd_x = 9'd400;
    tick();
    check("rd_oob_x", 32'(ram_rd_addr), 32'd0);
    sc_rd_x = 9'd3; sc_rd_y = 9'd1;
    tick();
    check("rd_403", 32'(ram_rd_addr), 32'd403);
    sc_rd_x = 9'd10; sc_rd_y = 9'd300;
    tick();
    check("rd_oob_y", 32'(ram_rd_addr), 32'd0);

    // Out-of-range writes: handshake completes, no RAM strobe
    gpu_wr_valid = 1'b1; gpu_wr_x = 9'd450; gpu_wr_y = 9'd0;
    check("oob_ready", 32'(gpu_wr_ready), 32'd1);
    tick();
    check("oob_x_wr_en", 32'(ram_wr_en), 32'd0);
    gpu_wr_x = 9'd0; gpu_wr_y = 9'd300;
    tick();
    gpu_wr_valid = 1'b0;
    check("oob_y_wr_en", 32'(ram_wr_en), 32'd0);

    // Swap request waits for vblank; writes blocked meanwhile
    swap_req = 1'b1;
    tick();
    gpu_wr_valid = 1'b1; gpu_wr_x = 9'd1; gpu_wr_y = 9'd1;
    for (int i = 0; i < 8; i++) begin
      check("wait_ready", 32'(gpu_wr_ready), 32'd0);
      tick();
      check("wait_wr_en", 32'(ram_wr_en), 32'd0);
      check("wait_bank", 32'(front_bank), 32'd0);
    end
    gpu_wr_valid = 1'b0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    check("swap1_bank", 32'(front_bank), 32'd1);
    check("swap1_ack", 32'(swap_ack), 32'd1);
    check("swap1_count", 32'(frame_count), 32'd1);
    check("swap1_ready", 32'(gpu_wr_ready), 32'd1);
    // swap_req still high during the ack cycle must not start a new request
    tick();
    swap_req = 1'b0;
    check("ack_pulse", 32'(swap_ack), 32'd0);
    check("no_rerequest", 32'(gpu_wr_ready), 32'd1);

    // Simultaneous request and vblank in IDLE
    swap_req = 1'b1; vblank_start = 1'b1;
    tick();
    swap_req = 1'b0; vblank_start = 1'b0;
    check("imm_bank", 32'(front_bank), 32'd0);
    check("imm_ack", 32'(swap_ack), 32'd1);
    check("imm_count", 32'(frame_count), 32'd2);
    tick();
    check("imm_ack_low", 32'(swap_ack), 32'd0);

    // Early-dropped request stays latched
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (3) tick();
    check("drop_ready", 32'(gpu_wr_ready), 32'd0);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    check("drop_bank", 32'(front_bank), 32'd1);
    check("drop_ack", 32'(swap_ack), 32'd1);
    check("drop_count", 32'(frame_count), 32'd3);

    // Lone vblank in IDLE has no effect
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    check("vb_only_bank", 32'(front_bank), 32'd1);
    check("vb_only_ack", 32'(swap_ack), 32'd0);
    check("vb_only_count", 32'(frame_count), 32'd3);

    // Banks follow front_bank=1
    sc_rd_x = 9'd5; sc_rd_y = 9'd2;
    gpu_wr_valid = 1'b1; gpu_wr_x = 9'd5; gpu_wr_y = 9'd2; gpu_wr_color = 16'h1234;
    tick();
    gpu_wr_valid = 1'b0;
    check("rd_bank1", 32'(ram_rd_addr), 32'(18'h20000 + 18'd805));
    check("wr_bank0", 32'(ram_wr_addr), 32'd805);
    check("wr_data2", 32'(ram_wr_data), 32'h1234);

    // Reset during WAIT_VBLANK aborts without ack
    swap_req = 1'b1;
    tick();
    check("rst_wait_ready", 32'(gpu_wr_ready), 32'd0);
    reset = 1'b1;
    tick();
    swap_req = 1'b0;
    check("abort_bank", 32'(front_bank), 32'd0);
    check("abort_ack", 32'(swap_ack), 32'd0);
    check("abort_count", 32'(frame_count), 32'd0);
    check("abort_ready", 32'(gpu_wr_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("abort_idle", 32'(gpu_wr_ready), 32'd1);

    // In-flight write dropped by reset
    gpu_wr_valid = 1'b1; gpu_wr_x = 9'd2; gpu_wr_y = 9'd0;
    tick();
    gpu_wr_valid = 1'b0;
    check("flight_en", 32'(ram_wr_en), 32'd1);
    reset = 1'b1;
    tick();
    check("flight_drop", 32'(ram_wr_en), 32'd0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
